// File: rtl/nonce_result_scanner.sv
// Purpose : scans NUM_OF_NONCES h0 words from memory, reports first hit, minimum hash and hit count.
// Latency : start accepted in cycle T -> REPORT in T+N+2, done=1 with final results from T+N+3.
// Backpressure: none; one word read per cycle, start is ignored (not queued) while busy.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 one-cycle scan request, sampled only in IDLE
//   result_addr, target   base address of word 0 and difficulty target, latched on start
//   done                  high exactly while in IDLE
//   mem_clk, mem_we,      single-port memory read interface; data valid one cycle
//   mem_addr, mem_read_data   after its address, mem_we is always 0
//   found, found_nonce    any word < target, and the lowest such nonce index
//   min_hash, min_nonce   smallest word scanned and its nonce index
//   hit_count             number of words < target
//   hit_mask              only when SCAN_HIT_MASK_EN is defined: bit n set when word n < target
module nonce_result_scanner #(
   parameter int NUM_OF_NONCES = 16,
   parameter int CNT_W         = $clog2(NUM_OF_NONCES + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [15:0]              result_addr,
   input  logic [31:0]              target,
   output logic                     done,
   output logic                     mem_clk,
   output logic                     mem_we,
   output logic [15:0]              mem_addr,
   input  logic [31:0]              mem_read_data,
   output logic                     found,
   output logic [31:0]              found_nonce,
   output logic [31:0]              min_hash,
   output logic [31:0]              min_nonce,
   output logic [CNT_W-1:0]         hit_count
`ifdef SCAN_HIT_MASK_EN
   ,output logic [NUM_OF_NONCES-1:0] hit_mask
`endif
);

   // idx runs 0..NUM_OF_NONCES inclusive: one extra cycle drains the last read.
   localparam int IDX_W = $clog2(NUM_OF_NONCES + 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OF_NONCES);
   localparam logic [IDX_W-1:0] IDX_ADDR_END = IDX_W'(NUM_OF_NONCES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      REPORT = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] idx;
   logic [15:0]      base;
   logic [31:0]      target_q;

   logic             capture;
   logic [IDX_W-1:0] nonce;
   logic [IDX_W-1:0] idx_inc;
   logic             hit;
   logic             new_min;

   assign mem_clk = clk;
   assign mem_we  = 1'b0;
   assign done    = (state == IDLE);

   // Word for nonce idx-1 arrives while idx is presented, so idx==0 has nothing to capture.
   assign capture = (state == READ) && (idx != '0);
   assign nonce   = idx - IDX_W'(1);
   assign idx_inc = idx + IDX_W'(1);
   assign hit     = (mem_read_data < target_q);
   assign new_min = (mem_read_data < min_hash);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = READ;
         READ:    if (idx == IDX_LAST) state_nxt = REPORT;
         REPORT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx         <= '0;
         base        <= '0;
         target_q    <= '0;
         mem_addr    <= '0;
         found       <= 1'b0;
         found_nonce <= '0;
         min_hash    <= 32'hFFFF_FFFF;
         min_nonce   <= '0;
         hit_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx         <= '0;
                  base        <= result_addr;
                  target_q    <= target;
                  // Address of word 0 is registered here so it is on the bus in the first READ cycle.
                  mem_addr    <= result_addr;
                  found       <= 1'b0;
                  found_nonce <= '0;
                  min_hash    <= 32'hFFFF_FFFF;
                  min_nonce   <= '0;
                  hit_count   <= '0;
               end
            end
            READ: begin
               if (idx != IDX_LAST) begin
                  idx <= idx_inc;
               end
               // Stop advancing after the last word's address; mem_addr then holds.
               if (idx < IDX_ADDR_END) begin
                  mem_addr <= base + 16'(idx_inc);
               end
               if (capture) begin
                  if (hit) begin
                     hit_count <= hit_count + CNT_W'(1);
                     if (!found) begin
                        found       <= 1'b1;
                        found_nonce <= 32'(nonce);
                     end
                  end
                  // Strict compare keeps the lower nonce on ties.
                  if (new_min) begin
                     min_hash  <= mem_read_data;
                     min_nonce <= 32'(nonce);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef SCAN_HIT_MASK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_mask <= '0;
      end else if ((state == IDLE) && start) begin
         hit_mask <= '0;
      end else begin
         for (int i = 0; i < NUM_OF_NONCES; i++) begin
            if (capture && hit && (nonce == IDX_W'(i))) begin
               hit_mask[i] <= 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_nonce_result_scanner.sv
module tb_nonce_result_scanner;

   localparam int N  = 16;
   localparam int CW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [15:0]   result_addr = '0;
   logic [31:0]   target = '0;
   logic          done;
   logic          mem_clk;
   logic          mem_we;
   logic [15:0]   mem_addr;
   logic [31:0]   mem_read_data = '0;
   logic          found;
   logic [31:0]   found_nonce;
   logic [31:0]   min_hash;
   logic [31:0]   min_nonce;
   logic [CW-1:0] hit_count;
`ifdef SCAN_HIT_MASK_EN
   logic [N-1:0]  hit_mask;
`endif

   nonce_result_scanner #(.NUM_OF_NONCES(N)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .result_addr(result_addr),
      .target(target),
      .done(done),
      .mem_clk(mem_clk),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_read_data(mem_read_data),
      .found(found),
      .found_nonce(found_nonce),
      .min_hash(min_hash),
      .min_nonce(min_nonce),
      .hit_count(hit_count)
`ifdef SCAN_HIT_MASK_EN
      ,.hit_mask(hit_mask)
`endif
   );

   always #5 clk = ~clk;

   // Memory: data for the address seen at an edge is valid during the following cycle.
   logic [31:0] mem [0:65535];
   always @(posedge clk) mem_read_data <= mem[mem_addr];

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic         found;
      logic [31:0]  fn;
      logic [31:0]  mh;
      logic [31:0]  mn;
      int           hc;
      logic [N-1:0] mask;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] addr_log[$];
   bit          we_bad;
   int          done_cyc;

   // Reference model of a scan over the bench memory.
   function automatic exp_t model(input logic [15:0] b, input logic [31:0] t);
      exp_t        e;
      logic [31:0] w;
      e.found = 1'b0; e.fn = '0; e.mh = 32'hFFFF_FFFF; e.mn = '0; e.hc = 0; e.mask = '0;
      for (int i = 0; i < N; i++) begin
         w = mem[b + 16'(i)];
         if (w < t) begin
            e.hc++;
            e.mask[i] = 1'b1;
            if (!e.found) begin e.found = 1'b1; e.fn = 32'(i); end
         end
         if (w < e.mh) begin e.mh = w; e.mn = 32'(i); end
      end
      return e;
   endfunction

   task automatic start_scan(input logic [15:0] b, input logic [31:0] t);
      sb.push_back(model(b, t));
      @(posedge clk); #1;
      result_addr = b; target = t; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Called in cycle T+1; logs mem_addr per cycle, stops when done is seen or budget ends.
   // inject_at>0 raises start (with other operands) during cycle T+inject_at.
   task automatic wait_done(input int inject_at);
      int cyc;
      addr_log.delete();
      we_bad = 1'b0;
      cyc = 1;
      addr_log.push_back(mem_addr);
      if (mem_we !== 1'b0) we_bad = 1'b1;
      while (done !== 1'b1 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         start = (cyc == inject_at);
         if (start) begin result_addr = 16'h0000; target = 32'hFFFF_FFFF; end
         addr_log.push_back(mem_addr);
         if (mem_we !== 1'b0) we_bad = 1'b1;
      end
      start = 1'b0;
      done_cyc = cyc;
   endtask

   task automatic fill_basic();
      for (int i = 0; i < N; i++) mem[16'h0100 + 16'(i)] = 32'h8000_0000 - 32'(i) * 32'h0100_0000;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL reset_done got=%b want=1", done); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
      checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL reset_mem_addr got=%h want=0000", mem_addr); end
      checks++; if (found !== 1'b0) begin failures++; $display("FAIL reset_found got=%b want=0", found); end
      checks++; if (found_nonce !== 32'h0) begin failures++; $display("FAIL reset_found_nonce got=%h want=0", found_nonce); end
      checks++; if (min_hash !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_min_hash got=%h want=ffffffff", min_hash); end
      checks++; if (min_nonce !== 32'h0) begin failures++; $display("FAIL reset_min_nonce got=%h want=0", min_nonce); end
      checks++; if (hit_count !== CW'(0)) begin failures++; $display("FAIL reset_hit_count got=%0d want=0", hit_count); end
   endtask

   task automatic test_basic();
      exp_t e;
      fill_basic();
      start_scan(16'h0100, 32'h7800_0000);
      wait_done(0);
      e = sb.pop_front();
      checks++; if (done_cyc != 19) begin failures++; $display("FAIL basic_done_latency got=%0d want=19", done_cyc); end
      checks++; if (addr_log[0] !== 16'h0100) begin failures++; $display("FAIL basic_first_addr got=%h want=0100", addr_log[0]); end
      checks++; if (found !== e.found) begin failures++; $display("FAIL basic_found got=%b want=%b", found, e.found); end
      checks++; if (found_nonce !== 32'd9) begin failures++; $display("FAIL basic_found_nonce got=%0d want=9", found_nonce); end
      checks++; if (hit_count !== CW'(e.hc)) begin failures++; $display("FAIL basic_hit_count got=%0d want=%0d", hit_count, e.hc); end
      checks++; if (hit_count !== CW'(7)) begin failures++; $display("FAIL basic_hit_count_const got=%0d want=7", hit_count); end
      checks++; if (min_hash !== 32'h7100_0000) begin failures++; $display("FAIL basic_min_hash got=%h want=71000000", min_hash); end
      checks++; if (min_nonce !== e.mn) begin failures++; $display("FAIL basic_min_nonce got=%0d want=%0d", min_nonce, e.mn); end
`ifdef SCAN_HIT_MASK_EN
      checks++; if (hit_mask !== 16'hFE00) begin failures++; $display("FAIL basic_hit_mask got=%h want=fe00", hit_mask); end
`endif
   endtask

   task automatic test_no_hit();
      exp_t e;
      for (int i = 0; i < N; i++) mem[16'h0200 + 16'(i)] = 32'h0000_1234;
      start_scan(16'h0200, 32'h0);
      wait_done(0);
      e = sb.pop_front();
      checks++; if (found !== 1'b0) begin failures++; $display("FAIL nohit_found got=%b want=0", found); end
      checks++; if (found_nonce !== e.fn) begin failures++; $display("FAIL nohit_found_nonce got=%0d want=%0d", found_nonce, e.fn); end
      checks++; if (hit_count !== CW'(0)) begin failures++; $display("FAIL nohit_hit_count got=%0d want=0", hit_count); end
      checks++; if (min_hash !== 32'h0000_1234) begin failures++; $display("FAIL nohit_min_hash got=%h want=00001234", min_hash); end
      checks++; if (min_nonce !== 32'h0) begin failures++; $display("FAIL nohit_min_nonce got=%0d want=0", min_nonce); end
`ifdef SCAN_HIT_MASK_EN
      checks++; if (hit_mask !== '0) begin failures++; $display("FAIL nohit_hit_mask got=%h want=0", hit_mask); end
`endif
   endtask

   task automatic test_all_ones();
      exp_t e;
      for (int i = 0; i < N; i++) mem[16'h0400 + 16'(i)] = 32'hFFFF_FFFF;
      start_scan(16'h0400, 32'hFFFF_FFFF);
      wait_done(0);
      e = sb.pop_front();
      checks++; if (found !== e.found) begin failures++; $display("FAIL ones_found got=%b want=%b", found, e.found); end
      checks++; if (hit_count !== CW'(0)) begin failures++; $display("FAIL ones_hit_count got=%0d want=0", hit_count); end
      checks++; if (min_hash !== 32'hFFFF_FFFF) begin failures++; $display("FAIL ones_min_hash got=%h want=ffffffff", min_hash); end
      checks++; if (min_nonce !== 32'h0) begin failures++; $display("FAIL ones_min_nonce got=%0d want=0", min_nonce); end
   endtask

   task automatic test_tie();
      exp_t e;
      for (int i = 0; i < N; i++) mem[16'h0300 + 16'(i)] = 32'hFFFF_FFFF;
      mem[16'h0305] = 32'h0000_0010;
      mem[16'h030B] = 32'h0000_0010;
      start_scan(16'h0300, 32'h0000_0011);
      wait_done(0);
      e = sb.pop_front();
      checks++; if (found_nonce !== 32'd5) begin failures++; $display("FAIL tie_found_nonce got=%0d want=5", found_nonce); end
      checks++; if (min_nonce !== 32'd5) begin failures++; $display("FAIL tie_min_nonce got=%0d want=5", min_nonce); end
      checks++; if (hit_count !== CW'(2)) begin failures++; $display("FAIL tie_hit_count got=%0d want=2", hit_count); end
      checks++; if (min_hash !== e.mh) begin failures++; $display("FAIL tie_min_hash got=%h want=%h", min_hash, e.mh); end
   endtask

   task automatic test_addr_wrap();
      exp_t        e;
      logic [15:0] want[$];
      for (int i = 0; i < N; i++) begin
         mem[16'hFFF8 + 16'(i)] = 32'(1000 - i * 7);
         want.push_back(16'hFFF8 + 16'(i));
      end
      start_scan(16'hFFF8, 32'hFFFF_FFFF);
      wait_done(0);
      e = sb.pop_front();
      for (int i = 0; i < N; i++) begin
         logic [15:0] w;
         w = want.pop_front();
         checks++; if (addr_log[i] !== w) begin failures++; $display("FAIL wrap_addr[%0d] got=%h want=%h", i, addr_log[i], w); end
      end
      checks++; if (we_bad) begin failures++; $display("FAIL wrap_mem_we got=1 want=0"); end
      checks++; if (mem_addr !== 16'h0007) begin failures++; $display("FAIL wrap_addr_hold got=%h want=0007", mem_addr); end
      checks++; if (hit_count !== CW'(e.hc)) begin failures++; $display("FAIL wrap_hit_count got=%0d want=%0d", hit_count, e.hc); end
      checks++; if (min_nonce !== 32'd15) begin failures++; $display("FAIL wrap_min_nonce got=%0d want=15", min_nonce); end
      checks++; if (found_nonce !== 32'd0) begin failures++; $display("FAIL wrap_found_nonce got=%0d want=0", found_nonce); end
   endtask

   task automatic test_reset_mid_scan();
      exp_t e;
      fill_basic();
      start_scan(16'h0100, 32'h7800_0000);
      e = sb.pop_back();
      // Now in cycle T+1 (idx=0); move to idx=7 and reset there.
      repeat (7) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL midrst_done got=%b want=1", done); end
      checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL midrst_mem_addr got=%h want=0000", mem_addr); end
      checks++; if (min_hash !== 32'hFFFF_FFFF) begin failures++; $display("FAIL midrst_min_hash got=%h want=ffffffff", min_hash); end
      checks++; if (min_nonce !== 32'h0) begin failures++; $display("FAIL midrst_min_nonce got=%0d want=0", min_nonce); end
      checks++; if (hit_count !== CW'(0)) begin failures++; $display("FAIL midrst_hit_count got=%0d want=0", hit_count); end
      start_scan(16'h0100, 32'h7800_0000);
      wait_done(0);
      e = sb.pop_front();
      checks++; if (done_cyc != 19) begin failures++; $display("FAIL midrst_latency got=%0d want=19", done_cyc); end
      checks++; if (found_nonce !== e.fn) begin failures++; $display("FAIL midrst_found_nonce got=%0d want=%0d", found_nonce, e.fn); end
      checks++; if (hit_count !== CW'(e.hc)) begin failures++; $display("FAIL midrst_hit_count_rerun got=%0d want=%0d", hit_count, e.hc); end
      checks++; if (min_hash !== e.mh) begin failures++; $display("FAIL midrst_min_hash_rerun got=%h want=%h", min_hash, e.mh); end
   endtask

   task automatic test_start_ignored();
      exp_t e;
      for (int i = 0; i < N; i++) mem[16'(i)] = 32'h0;
      // Start pulse during READ (cycle T+5), then during REPORT (cycle T+18).
      start_scan(16'h0300, 32'h0000_0011);
      wait_done(5);
      e = sb.pop_front();
      checks++; if (done_cyc != 19) begin failures++; $display("FAIL ign_read_latency got=%0d want=19", done_cyc); end
      checks++; if (hit_count !== CW'(e.hc)) begin failures++; $display("FAIL ign_read_hit_count got=%0d want=%0d", hit_count, e.hc); end
      checks++; if (min_nonce !== e.mn) begin failures++; $display("FAIL ign_read_min_nonce got=%0d want=%0d", min_nonce, e.mn); end
      start_scan(16'h0300, 32'h0000_0011);
      wait_done(18);
      e = sb.pop_front();
      @(posedge clk); #1;
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL ign_report_done got=%b want=1", done); end
      checks++; if (hit_count !== CW'(e.hc)) begin failures++; $display("FAIL ign_report_hit_count got=%0d want=%0d", hit_count, e.hc); end
      checks++; if (found_nonce !== e.fn) begin failures++; $display("FAIL ign_report_found_nonce got=%0d want=%0d", found_nonce, e.fn); end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
      test_reset();
      test_basic();
      test_no_hit();
      test_all_ones();
      test_tie();
      test_addr_wrap();
      test_reset_mid_scan();
      test_start_ignored();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
